// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between pipeline writeback
//            and a FIFO of mul/div results, with a pending-register scoreboard.
// Revision : 1.0
// ============================================================================
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wdata,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_wdata,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        pending_rs,
    output logic        pending_rt,
    output logic        stall_req,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_data,
    output logic [3:0]  q_count
);
    localparam int         c_PTR_W = $clog2(DEPTH);
    localparam logic [3:0] c_DEPTH = 4'(DEPTH);
    localparam logic [7:0] c_LIMIT = 8'(STARVE_LIMIT);

    logic [4:0]         r_mem_rd   [DEPTH];
    logic [31:0]        r_mem_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [3:0]         r_count;
    logic [31:0]        r_pending;
    logic [7:0]         r_age;
    logic               r_stall;

    logic               w_pipe_active;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic [4:0]         w_head_rd;
    logic [31:0]        w_head_data;
    logic [31:0]        w_pending_nxt;

    assign w_pipe_active = pipe_we && (pipe_rd != 5'd0);
    assign w_empty       = (r_count == 4'd0);
    assign md_ready      = !reset && (r_count < c_DEPTH);
    assign w_push        = md_valid && md_ready && (md_rd != 5'd0);
    // Queued results are dropped, never written, while reset is asserted.
    assign w_pop         = !reset && !w_pipe_active && !w_empty;
    assign w_head_rd     = r_mem_rd[r_rd_ptr];
    assign w_head_data   = r_mem_data[r_rd_ptr];

    assign q_count    = r_count;
    assign stall_req  = r_stall;
    assign pending_rs = r_pending[rs];
    assign pending_rt = r_pending[rt];

    always_comb begin
        RegWrite       = 1'b0;
        Write_register = 5'd0;
        Write_data     = 32'd0;
        if (w_pipe_active) begin
            RegWrite       = 1'b1;
            Write_register = pipe_rd;
            Write_data     = pipe_wdata;
        end else if (w_pop) begin
            RegWrite       = 1'b1;
            Write_register = w_head_rd;
            Write_data     = w_head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= md_rd;
            r_mem_data[r_wr_ptr] <= md_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) w_pending_nxt[w_head_rd] = 1'b0;
        if (md_issue && (md_issue_rd != 5'd0)) w_pending_nxt[md_issue_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) r_pending <= 32'd0;
        else       r_pending <= w_pending_nxt;
    end

    // A non-empty FIFO without a pop means the head was blocked by the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_age   <= 8'd0;
            r_stall <= 1'b0;
        end else if (w_empty || w_pop) begin
            r_age   <= 8'd0;
            r_stall <= 1'b0;
        end else begin
            if (r_age != 8'hFF) r_age <= r_age + 8'd1;
            r_stall <= (r_age >= c_LIMIT);
        end
    end
endmodule
`default_nettype wire
